pipeline_ctrl: RTL
==================

# pipeline_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It merges the hazard unit's load-use `stall` and mispredict `flush` with instruction/data memory wait handshakes and a halt-drain sequence. From these it produces per-stage write-enables and bubble/flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps cycle, stall and flush performance counters.

## Interface
- `CNT_W`, 32, width of each performance counter
- `clk` in 1 core clock
- `reset_n` in 1 reset; asynchronous, active-low
- `hz_stall` in 1 load-use stall from the hazard unit (ID-stage instruction)
- `hz_flush` in 1 mispredict flush from the hazard unit (resolved in MEM)
- `imem_ready` in 1 fetch for current PC completes this cycle
- `dmem_req` in 1 MEM stage holds a load/store
- `dmem_ready` in 1 data access completes this cycle
- `halt_req` in 1 ID stage holds ecall/ebreak
- `pc_we`, `if_id_we`, `id_ex_we`, `ex_mem_we`, `mem_wb_we` out 1 register load enables
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush` out 1 load bubble (NOP, valid=0) instead of data; only meaningful with the matching `_we`=1
- `halted` out 1 core halted
- `cycle_cnt`, `stall_cnt`, `flush_cnt` out CNT_W performance counters

## Operation
- FSM states: RUN, DRAIN, HALTED. 2-bit `drain_cnt` tracks the halt instruction's stage: 0=EX, 1=MEM, 2=WB.
- "advance" is true when the freeze condition below does not hold.
- Stage controls are combinational, evaluated in strict priority order:
  1. HALTED: all `_we`=0, all `_flush`=0.
  2. freeze (`dmem_req && !dmem_ready`): `pc_we`, `if_id_we`, `id_ex_we`, `ex_mem_we`=0. `mem_wb_we`=1 with `mem_wb_flush`=1, so WB never recommits. `hz_flush` and `halt_req` are ignored; the hazard unit re-presents them.
  3. `hz_flush`: all `_we`=1; `if_id_flush`, `id_ex_flush`, `ex_mem_flush`=1; PC loads the redirect target.
  4. `hz_stall`: `pc_we`=0, `if_id_we`=0; `id_ex_flush`=1; the other stages advance.
  5. DRAIN, or RUN with `!imem_ready`: `pc_we`=0; `if_id_flush`=1; the rest advance.
  6. Otherwise all `_we`=1, all `_flush`=0.
- Transitions:
  - RUN→DRAIN, `drain_cnt`=0: when `halt_req` and rule 6 applies, or rule 5 applies because of `!imem_ready`.
  - `halt_req` under rules 2–4 is not accepted.
  - DRAIN with advance: `drain_cnt`+1. At `drain_cnt`=2 with advance → HALTED.
  - DRAIN with `hz_flush` and `drain_cnt`=0 → RUN (the halt instruction was on the wrong path). With `drain_cnt`≥1, `hz_flush` follows rule 3 but the state is unchanged.
  - HALTED exits only on reset.
- Counters wrap modulo 2^CNT_W and are frozen in HALTED.
  - `cycle_cnt` +1 every non-HALTED cycle.
  - `stall_cnt` +1 on cycles where rule 2, 4 or 5 applies.
  - `flush_cnt` +1 on cycles where rule 3 applies.

## Timing
- Reset (async assert, sync-released flops):
  - state=RUN, `drain_cnt`=0, all counters 0, `halted`=0.
  - Outputs evaluate per the rules above; during reset, RUN with no inputs gives all `_we`=1, `_flush`=0.
- Stage controls have zero latency from inputs. `halted` is registered, asserting the cycle after the final DRAIN advance.
- A multi-cycle freeze holds every register, including `drain_cnt`. The pending flush or stall acts on the first cycle with `dmem_ready`=1.
- Counter values reflect a cycle's events from the next edge.

## Structure
- `pipeline_ctrl_pkg` holds:
  - the state enum (RUN/DRAIN/HALTED);
  - `DRAIN_LAST`=2;
  - the bubble-select encoding shared with the stage registers.
- Sub-module `ctrl_perf_cnt`: a parameterised CNT_W wrapping counter with enable and freeze inputs, instantiated three times.
- FSM and priority decode stay in `pipeline_ctrl`.

## Test plan
- Load-use: `hz_stall`=1 for 1 cycle → `pc_we`=0, `if_id_we`=0, `id_ex_flush`=1, `mem_wb_we`=1; `stall_cnt` 0→1.
- Data wait: `dmem_req`=1, `dmem_ready`=0 for 3 cycles with `hz_flush`=1 held:
  - those 3 cycles → `mem_wb_flush`=1 with `mem_wb_we`=1 and every other `_we`=0;
  - cycle 4 (`dmem_ready`=1) → three flushes asserted;
  - `stall_cnt`=3, `flush_cnt`=1.
- Flush vs imiss: `hz_flush`=1 with `imem_ready`=0 → `pc_we`=1, IF/ID, ID/EX, EX/MEM flushed, no stall count.
- Halt: `halt_req` in RUN with rule 6 → DRAIN; 3 advancing cycles, one of them frozen → `halted`=1 exactly after the 3rd advance; `cycle_cnt` stops.
- Wrong-path halt: `hz_flush` at `drain_cnt`=0 → state RUN, `halted` stays 0.
- Wrap and reset: CNT_W=4, 16 flushes → `flush_cnt`=0. `reset_n` low mid-DRAIN → state RUN, counters 0, `halted`=0 immediately.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// pipeline_ctrl_pkg : shared types for the pipeline sequencing controller
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    HALTED  = 2'd2
  } state_e;

  // drain_cnt value when the halting instruction sits in WB
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  // Stage-register control: bit 1 = load enable, bit 0 = load a bubble
  typedef enum logic [1:0] {
    SEL_HOLD   = 2'b00,
    SEL_LOAD   = 2'b10,
    SEL_BUBBLE = 2'b11
  } stage_sel_e;

endpackage

`default_nettype wire

// File: rtl/ctrl_perf_cnt.sv
// ============================================================================
// ctrl_perf_cnt : wrapping performance counter with enable and freeze
// Rev 1.0
// ============================================================================
`default_nettype none

module ctrl_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             freeze,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (en && !freeze) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// pipeline_ctrl : stage enables/bubbles, halt drain FSM and perf counters
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hz_stall,
  input  logic             hz_flush,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;

  logic       freeze;
  logic       stall_ev;
  logic       flush_ev;
  logic       pc_load;
  stage_sel_e if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel;

  assign freeze = dmem_req && !dmem_ready;

  always_comb begin
    pc_load    = 1'b1;
    if_id_sel  = SEL_LOAD;
    id_ex_sel  = SEL_LOAD;
    ex_mem_sel = SEL_LOAD;
    mem_wb_sel = SEL_LOAD;
    stall_ev   = 1'b0;
    flush_ev   = 1'b0;

    if (state_q == HALTED) begin
      pc_load    = 1'b0;
      if_id_sel  = SEL_HOLD;
      id_ex_sel  = SEL_HOLD;
      ex_mem_sel = SEL_HOLD;
      mem_wb_sel = SEL_HOLD;
    end else if (freeze) begin
      // WB still loads, but a bubble, so the stalled MEM op never commits twice
      pc_load    = 1'b0;
      if_id_sel  = SEL_HOLD;
      id_ex_sel  = SEL_HOLD;
      ex_mem_sel = SEL_HOLD;
      mem_wb_sel = SEL_BUBBLE;
      stall_ev   = 1'b1;
    end else if (hz_flush) begin
      if_id_sel  = SEL_BUBBLE;
      id_ex_sel  = SEL_BUBBLE;
      ex_mem_sel = SEL_BUBBLE;
      flush_ev   = 1'b1;
    end else if (hz_stall) begin
      pc_load    = 1'b0;
      if_id_sel  = SEL_HOLD;
      id_ex_sel  = SEL_BUBBLE;
      stall_ev   = 1'b1;
    end else if (state_q == DRAIN || !imem_ready) begin
      pc_load    = 1'b0;
      if_id_sel  = SEL_BUBBLE;
      stall_ev   = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      RUN: begin
        if (halt_req && !freeze && !hz_flush && !hz_stall) begin
          state_d     = DRAIN;
          drain_cnt_d = 2'd0;
        end
      end
      DRAIN: begin
        if (!freeze) begin
          if (hz_flush && drain_cnt_q == 2'd0) begin
            state_d = RUN;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            state_d = HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q + 2'd1;
          end
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      drain_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign pc_we        = pc_load;
  assign if_id_we     = if_id_sel[1];
  assign id_ex_we     = id_ex_sel[1];
  assign ex_mem_we    = ex_mem_sel[1];
  assign mem_wb_we    = mem_wb_sel[1];
  assign if_id_flush  = if_id_sel[0];
  assign id_ex_flush  = id_ex_sel[0];
  assign ex_mem_flush = ex_mem_sel[0];
  assign mem_wb_flush = mem_wb_sel[0];
  assign halted       = (state_q == HALTED);

  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .freeze  (halted),
    .count   (cycle_cnt)
  );

  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (stall_ev),
    .freeze  (halted),
    .count   (stall_cnt)
  );

  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (flush_ev),
    .freeze  (halted),
    .count   (flush_cnt)
  );

endmodule

`default_nettype wire
